// File: rtl/perceptron_mac_seq_if.sv
// Streaming bus of the sequential perceptron: upstream vector handshake
// (val_i/rdy_o/X_i) and downstream result handshake (val_o/rdy_i/Y_o/acc_o).
// Signal suffixes are from the perceptron's point of view.
interface perceptron_mac_seq_if #(
  parameter int WIDTH  = 8,
  parameter int WWIDTH = 4,
  parameter int N_IN   = 4
);
  localparam int ACC_W = WIDTH + WWIDTH + $clog2(N_IN + 1);

  logic                    val_i;
  logic                    rdy_o;
  logic [N_IN*WIDTH-1:0]   X_i;
  logic                    val_o;
  logic                    rdy_i;
  logic                    Y_o;
  logic signed [ACC_W-1:0] acc_o;

  // Perceptron side
  modport slave (
    input  val_i, X_i, rdy_i,
    output rdy_o, val_o, Y_o, acc_o
  );

  // Producer/consumer side
  modport master (
    output val_i, X_i, rdy_i,
    input  rdy_o, val_o, Y_o, acc_o
  );
endinterface

// File: rtl/perceptron_mac_seq.sv
// Sequential perceptron: computes sign(bias + sum W[i]*X[i]) using a single
// shared multiplier, one product per cycle, between val/rdy stream ports.
// Optional online training is enabled by defining PERCEPTRON_TRAIN_EN
// (adds train_i/t_i ports and a one-cycle weight UPDATE state).
module perceptron_mac_seq #(
  parameter int WIDTH  = 8,
  parameter int WWIDTH = 4,
  parameter int N_IN   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(N_IN+1)-1:0]     cfg_addr,
  input  logic signed [WWIDTH-1:0]      cfg_data,
`ifdef PERCEPTRON_TRAIN_EN
  input  logic                          train_i,
  input  logic                          t_i,
`endif
  perceptron_mac_seq_if.slave           io
);
  localparam int AW    = $clog2(N_IN + 1);
  localparam int ACC_W = WIDTH + WWIDTH + $clog2(N_IN + 1);
  localparam int PW    = WIDTH + WWIDTH;
  localparam int IW    = $clog2(N_IN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
`ifdef PERCEPTRON_TRAIN_EN
    S_DONE,
    S_UPDATE
`else
    S_DONE
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_o_q, acc_o_d;
  logic                    val_o_q, val_o_d;
  logic                    y_q, y_d;
  logic signed [WIDTH-1:0] x_q [N_IN];
  logic signed [WIDTH-1:0] x_d [N_IN];
  logic signed [WWIDTH-1:0] w_q [N_IN];
  logic signed [WWIDTH-1:0] w_d [N_IN];
  logic signed [WWIDTH-1:0] bias_q, bias_d;

  logic                    accept;
  logic                    out_fire;
  logic signed [WIDTH-1:0] x_sel;
  logic signed [WWIDTH-1:0] w_sel;
  logic signed [PW-1:0]    x_ext, w_ext, prod;
  logic signed [ACC_W-1:0] prod_ext, acc_sum, bias_ext;

  // Upstream is only accepted in IDLE and never in a cycle that writes config
  assign io.rdy_o = (state_q == S_IDLE) && !cfg_we;
  assign accept   = io.val_i && io.rdy_o;
  assign out_fire = val_o_q && io.rdy_i;

  assign io.val_o = val_o_q;
  assign io.Y_o   = y_q;
  assign io.acc_o = acc_o_q;

  // Shared multiplier: operands widened first so the product is exact
  assign x_sel    = x_q[idx_q];
  assign w_sel    = w_q[idx_q];
  assign x_ext    = {{(PW-WIDTH){x_sel[WIDTH-1]}}, x_sel};
  assign w_ext    = {{(PW-WWIDTH){w_sel[WWIDTH-1]}}, w_sel};
  assign prod     = w_ext * x_ext;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign acc_sum  = acc_q + prod_ext;
  assign bias_ext = {{(ACC_W-WWIDTH){bias_q[WWIDTH-1]}}, bias_q};

`ifdef PERCEPTRON_TRAIN_EN
  localparam logic signed [WWIDTH-1:0] W_MAX = {1'b0, {(WWIDTH-1){1'b1}}};
  localparam logic signed [WWIDTH-1:0] W_MIN = {1'b1, {(WWIDTH-1){1'b0}}};
  localparam logic signed [WWIDTH-1:0] W_ONE = {{(WWIDTH-1){1'b0}}, 1'b1};

  logic                     train_q, train_d;
  logic                     t_q, t_d;
  logic signed [WWIDTH-1:0] w_upd [N_IN];
  logic signed [WWIDTH-1:0] bias_upd;

  // Saturating +/-1 step; en=0 leaves the value untouched
  function automatic logic signed [WWIDTH-1:0] sat_step(
    input logic signed [WWIDTH-1:0] w, input logic en, input logic up);
    logic signed [WWIDTH-1:0] r;
    r = w;
    if (en) begin
      if (up) begin
        if (w != W_MAX) r = w + W_ONE;
      end else begin
        if (w != W_MIN) r = w - W_ONE;
      end
    end
    return r;
  endfunction

  // d*sgn(X[i]) is +1 exactly when X[i] is nonzero and its sign differs from t
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_upd
    assign w_upd[gi] = sat_step(w_q[gi], x_q[gi] != '0, x_q[gi][WIDTH-1] != t_q);
  end
  assign bias_upd = sat_step(bias_q, 1'b1, t_q);
`endif

  // Next-state and datapath updates for the control FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    acc_o_d = acc_o_q;
    val_o_d = val_o_q;
    y_d     = y_q;
    x_d     = x_q;
    w_d     = w_q;
    bias_d  = bias_q;
`ifdef PERCEPTRON_TRAIN_EN
    train_d = train_q;
    t_d     = t_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          if (cfg_addr < AW'(N_IN)) begin
            w_d[cfg_addr[IW-1:0]] = cfg_data;
          end else if (cfg_addr == AW'(N_IN)) begin
            bias_d = cfg_data;
          end
        end
        if (accept) begin
          for (int i = 0; i < N_IN; i++) begin
            x_d[i] = io.X_i[i*WIDTH +: WIDTH];
          end
          acc_d   = bias_ext;
          idx_d   = '0;
          state_d = S_MAC;
`ifdef PERCEPTRON_TRAIN_EN
          train_d = train_i;
          t_d     = t_i;
`endif
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N_IN - 1)) begin
          idx_d   = '0;
          acc_o_d = acc_sum;
          y_d     = !acc_sum[ACC_W-1];
          val_o_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_fire) begin
          val_o_d = 1'b0;
          state_d = S_IDLE;
`ifdef PERCEPTRON_TRAIN_EN
          if (train_q && (y_q != t_q)) state_d = S_UPDATE;
`endif
        end
      end
`ifdef PERCEPTRON_TRAIN_EN
      S_UPDATE: begin
        for (int i = 0; i < N_IN; i++) begin
          w_d[i] = w_upd[i];
        end
        bias_d  = bias_upd;
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      acc_o_q <= '0;
      val_o_q <= 1'b0;
      y_q     <= 1'b0;
      bias_q  <= '0;
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
`ifdef PERCEPTRON_TRAIN_EN
      train_q <= 1'b0;
      t_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      acc_o_q <= acc_o_d;
      val_o_q <= val_o_d;
      y_q     <= y_d;
      bias_q  <= bias_d;
      x_q     <= x_d;
      w_q     <= w_d;
`ifdef PERCEPTRON_TRAIN_EN
      train_q <= train_d;
      t_q     <= t_d;
`endif
    end
  end

endmodule

// File: tb/tb_perceptron_mac_seq.sv
// Testbench for perceptron_mac_seq: directed cases plus randomized vectors,
// compared against a plain-arithmetic model of weights, bias and dot product.
module tb_perceptron_mac_seq;
  localparam int WIDTH  = 8;
  localparam int WWIDTH = 4;
  localparam int N_IN   = 4;
`ifdef PERCEPTRON_TRAIN_EN
  localparam bit TRAIN = 1'b1;
`else
  localparam bit TRAIN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic signed [3:0] cfg_data = '0;
  logic       train_i = 1'b0;
  logic       t_i = 1'b0;

  perceptron_mac_seq_if #(.WIDTH(WIDTH), .WWIDTH(WWIDTH), .N_IN(N_IN)) io ();

  perceptron_mac_seq #(.WIDTH(WIDTH), .WWIDTH(WWIDTH), .N_IN(N_IN)) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
`ifdef PERCEPTRON_TRAIN_EN
    .train_i  (train_i),
    .t_i      (t_i),
`endif
    .io       (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int w_m [N_IN];
  int b_m;
  int xv_g [N_IN];
  int last_acc;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_w(input int v);
    if (v > 7) return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  function automatic int sgn(input int v);
    if (v > 0) return 1;
    if (v < 0) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) w_m[i] = 0;
    b_m = 0;
  endtask

  task automatic set_x(input int a, input int b, input int c, input int d);
    xv_g[0] = a; xv_g[1] = b; xv_g[2] = c; xv_g[3] = d;
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr[2:0];
    cfg_data = data[3:0];
    #1 check_val("cfg_blocks_rdy", 32'(io.rdy_o), 0);
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < N_IN) w_m[addr] = data;
    else if (addr == N_IN) b_m = data;
    $display("cfg addr=%0d data=%0d", addr, data);
  endtask

  // One full transaction: accept, MAC latency, optional backpressure, handshake
  task automatic run_vec(input int hold, input bit tr, input bit tv, input bit mac_cfg);
    int exp_acc;
    int lat;
    bit exp_y;
    bit upd;
    exp_acc = b_m;
    for (int i = 0; i < N_IN; i++) exp_acc += w_m[i] * xv_g[i];
    exp_y = (exp_acc >= 0);
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) io.X_i[i*WIDTH +: WIDTH] = xv_g[i][7:0];
    io.val_i = 1'b1;
    io.rdy_i = (hold == 0);
    train_i  = tr;
    t_i      = tv;
    check_val("rdy_idle", 32'(io.rdy_o), 1);
    @(negedge clk);
    io.val_i = 1'b0;
    io.X_i   = {$urandom, $urandom};
    check_val("rdy_busy", 32'(io.rdy_o), 0);
    if (mac_cfg) begin
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'sd7;
    end
    lat = 0;
    while (!io.val_o && lat < 20) begin
      @(negedge clk);
      cfg_we = 1'b0;
      lat++;
    end
    check_val("latency", lat, N_IN);
    check_val("acc", io.acc_o, exp_acc);
    check_val("y", 32'(io.Y_o), 32'(exp_y));
    last_acc = io.acc_o;
    for (int h = 0; h < hold; h++) begin
      io.val_i = 1'b1;
      io.X_i   = {$urandom, $urandom};
      @(negedge clk);
      check_val("bp_val", 32'(io.val_o), 1);
      check_val("bp_acc", io.acc_o, exp_acc);
      check_val("bp_y", 32'(io.Y_o), 32'(exp_y));
      check_val("bp_rdy", 32'(io.rdy_o), 0);
    end
    io.val_i = 1'b0;
    io.rdy_i = 1'b1;
    @(negedge clk);
    check_val("val_drop", 32'(io.val_o), 0);
    check_val("acc_keep", io.acc_o, exp_acc);
    check_val("y_keep", 32'(io.Y_o), 32'(exp_y));
    upd = TRAIN && tr && (exp_y != tv);
    if (upd) begin
      check_val("rdy_update", 32'(io.rdy_o), 0);
      for (int i = 0; i < N_IN; i++)
        w_m[i] = clamp_w(w_m[i] + (tv ? 1 : -1) * sgn(xv_g[i]));
      b_m = clamp_w(b_m + (tv ? 1 : -1));
      @(negedge clk);
    end
    check_val("rdy_back", 32'(io.rdy_o), 1);
    $display("vec x={%0d,%0d,%0d,%0d} hold=%0d train=%0d t=%0d acc=%0d exp=%0d y=%0d",
             xv_g[0], xv_g[1], xv_g[2], xv_g[3], hold, tr, tv, last_acc, exp_acc, exp_y);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    io.val_i = 1'b0;
    io.rdy_i = 1'b1;
    io.X_i   = '0;
    model_reset();

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_val", 32'(io.val_o), 0);
    check_val("rst_y", 32'(io.Y_o), 0);
    check_val("rst_acc", io.acc_o, 0);
    reset = 1'b1;
    #1 check_val("rst_rdy", 32'(io.rdy_o), 1);
    set_x(17, -5, 100, -128);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("unprog_acc", last_acc, 0);

    // Basic
    cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, -3); cfg_write(3, 4); cfg_write(4, -1);
    set_x(10, 5, 2, -1);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("basic_acc", last_acc, 9);

    // Extremes
    for (int i = 0; i < N_IN; i++) cfg_write(i, -8);
    cfg_write(4, 7);
    set_x(-128, -128, -128, -128);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("ext_pos", last_acc, 4103);
    cfg_write(4, -8);
    set_x(127, 127, 127, 127);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("ext_neg", last_acc, -4072);

    // Backpressure with val_i toggling while busy
    set_x(3, -7, 50, 1);
    run_vec(5, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("no_spurious", 32'(io.val_o), 0);

    // Config guards
    set_x(1, 0, 0, 0);
    run_vec(0, 1'b0, 1'b0, 1'b1);
    check_val("mac_cfg_ignored", last_acc, -16);
    cfg_write(5, 3);
    set_x(1, 1, 1, 1);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    io.val_i = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 4'sd2;
    #1 check_val("cfgval_rdy", 32'(io.rdy_o), 0);
    @(negedge clk);
    io.val_i = 1'b0; cfg_we = 1'b0;
    b_m = 2;
    repeat (6) @(negedge clk);
    check_val("cfgval_no_accept", 32'(io.val_o), 0);
    check_val("cfgval_idle", 32'(io.rdy_o), 1);
    $display("cfg+val cycle: no accept, bias=2");

    // Reset in the middle of a computation
    @(negedge clk);
    set_x(9, 9, 9, 9);
    for (int i = 0; i < N_IN; i++) io.X_i[i*WIDTH +: WIDTH] = 8'd9;
    io.val_i = 1'b1;
    @(negedge clk);
    io.val_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    check_val("abort_val", 32'(io.val_o), 0);
    check_val("abort_rdy", 32'(io.rdy_o), 1);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("abort_cleared", last_acc, 0);

`ifdef PERCEPTRON_TRAIN_EN
    // Perceptron learning step and saturation
    do_reset();
    set_x(3, -2, 0, 1);
    run_vec(0, 1'b1, 1'b0, 1'b0);
    set_x(1, 0, 0, 0);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("train_w0b", last_acc, -2);
    set_x(0, 1, 0, 1);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("train_w1w3b", last_acc, -1);
    cfg_write(0, -8); cfg_write(1, 7);
    set_x(1, 127, 0, 0);
    run_vec(0, 1'b1, 1'b0, 1'b0);
    set_x(1, 0, 0, 0);
    run_vec(0, 1'b0, 1'b0, 1'b0);
    check_val("train_sat", last_acc, -10);
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++)
        cfg_write($urandom_range(0, 7), $urandom_range(0, 15) - 8);
      set_x($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
            $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
      if (n % 7 == 0) xv_g[$urandom_range(0, 3)] = 0;
      run_vec($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
